// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag logic of the asynchronous FIFO: synchronises the read Gray
// pointer into wclk, advances the binary/Gray write pointers and derives full, level and overflow.
module fifo_wptr_full #(
    parameter int Addr_Width         = 9,
    parameter int Depth              = 512,
    parameter int Almost_Full_Thresh = 500,
    parameter int Sync_Stages        = 2
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [Addr_Width:0]   rptr_gray,
    input  logic                  clr_ovf,
    output logic [Addr_Width:0]   wr_addr,
    output logic [Addr_Width:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [Addr_Width:0]   wr_level,
    output logic                  overflow
);

    localparam int AW = Addr_Width;
    localparam int PW = Addr_Width + 1;
    localparam logic [AW:0] AF_THRESH = PW'(Almost_Full_Thresh);

    logic [Sync_Stages-1:0][AW:0] sync_q;
    logic [AW:0] rq;
    logic [AW:0] rbin_s;
    logic [AW:0] wbin_n;
    logic [AW:0] wgray_n;
    logic [AW:0] level_n;
    logic        wr_en;
    logic        full_n;

    // Binary equals the XOR of every right shift of the Gray code.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int unsigned s = 1; s <= AW; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    always_ff @(posedge wclk) begin
        if (wrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Sync_Stages-2:0], rptr_gray};
        end
    end

    assign rq = sync_q[Sync_Stages-1];

    always_comb begin
        wr_en   = winc & ~full;
        rbin_s  = gray2bin(rq);
        wbin_n  = wr_addr + {{AW{1'b0}}, wr_en};
        wgray_n = wbin_n ^ (wbin_n >> 1);
        level_n = wbin_n - rbin_s;
        // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
        full_n  = (wgray_n == {~rq[AW:AW-1], rq[AW-2:0]});
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wr_addr     <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wr_addr     <= wbin_n;
            wptr_gray   <= wgray_n;
            full        <= full_n;
            almost_full <= (level_n >= AF_THRESH);
            wr_level    <= level_n;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            overflow <= 1'b0;
        end else if (winc && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full: vector table plus fill, drain, wrap
// and mid-fill reset sequences.
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [9:0] rptr_gray;
    logic       clr_ovf;
    logic [9:0] wr_addr;
    logic [9:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [9:0] wr_level;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    fifo_wptr_full #(
        .Addr_Width(9),
        .Depth(512),
        .Almost_Full_Thresh(500),
        .Sync_Stages(2)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .winc(winc),
        .rptr_gray(rptr_gray),
        .clr_ovf(clr_ovf),
        .wr_addr(wr_addr),
        .wptr_gray(wptr_gray),
        .full(full),
        .almost_full(almost_full),
        .wr_level(wr_level),
        .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       wrst;
        logic       winc;
        logic       clr;
        logic [9:0] rg;
        logic [9:0] addr;
        logic [9:0] gray;
        logic       full;
        logic       af;
        logic [9:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [9:0] gray(input logic [9:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".wptr_gray"}, 32'(wptr_gray), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".almost_full"}, 32'(almost_full), 0);
        chk({tag, ".wr_level"}, 32'(wr_level), 0);
        chk({tag, ".overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b0; rptr_gray = '0; clr_ovf = 1'b0;
        step();
        step();

        //            wrst  winc  clr   rg      addr    gray    full  af    lvl     ovf
        vecs[0] = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 10'h000, 1'b0, 1'b0, 10'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd1, 10'h001, 1'b0, 1'b0, 10'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd2, 10'h003, 1'b0, 1'b0, 10'd2, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 10'd0, 10'd2, 10'h003, 1'b0, 1'b0, 10'd2, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd3, 10'h002, 1'b0, 1'b0, 10'd3, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 10'd0, 10'd4, 10'h006, 1'b0, 1'b0, 10'd4, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 10'h000, 1'b0, 1'b0, 10'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd1, 10'h001, 1'b0, 1'b0, 10'd1, 1'b0};

        foreach (vecs[i]) begin
            wrst = vecs[i].wrst; winc = vecs[i].winc;
            clr_ovf = vecs[i].clr; rptr_gray = vecs[i].rg;
            step();
            chk($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d.wptr_gray", i), 32'(wptr_gray), 32'(vecs[i].gray));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("vec%0d.wr_level", i), 32'(wr_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Reset with winc high, then fill to full.
        wrst = 1'b1; winc = 1'b1; clr_ovf = 1'b0; rptr_gray = '0;
        step();
        chk_zero("reset");
        wrst = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            step();
            chk($sformatf("fill%0d.wr_addr", i), 32'(wr_addr), 32'(i));
            if (i == 499) chk("af_at_499", 32'(almost_full), 0);
            if (i == 500) chk("af_at_500", 32'(almost_full), 1);
            if (i == 511) chk("full_at_511", 32'(full), 0);
        end
        chk("full.wr_addr", 32'(wr_addr), 32'h200);
        chk("full.wptr_gray", 32'(wptr_gray), 32'h300);
        chk("full.full", 32'(full), 1);
        chk("full.wr_level", 32'(wr_level), 512);
        chk("full.overflow", 32'(overflow), 0);

        step();
        chk("ovf513.wr_addr", 32'(wr_addr), 32'h200);
        chk("ovf513.overflow", 32'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        chk("ovf_set_wins", 32'(overflow), 1);
        winc = 1'b0;
        step();
        chk("ovf_clear", 32'(overflow), 0);
        clr_ovf = 1'b0;

        // One read crosses the synchroniser: full holds for two edges.
        rptr_gray = 10'h001;
        step();
        chk("drain1.full", 32'(full), 1);
        chk("drain1.wr_level", 32'(wr_level), 512);
        step();
        chk("drain2.full", 32'(full), 1);
        step();
        chk("drain3.full", 32'(full), 0);
        chk("drain3.wr_level", 32'(wr_level), 511);
        chk("drain3.almost_full", 32'(almost_full), 1);

        // Walk both pointers to binary 1023 then wrap.
        wrst = 1'b1; rptr_gray = '0;
        step();
        wrst = 1'b0; winc = 1'b1;
        for (int k = 0; k < 1023; k++) begin
            rptr_gray = gray(10'(k));
            step();
            if (full !== 1'b0) chk($sformatf("walk%0d.full", k), 32'(full), 0);
        end
        winc = 1'b0;
        chk("walk.wr_addr", 32'(wr_addr), 1023);
        chk("walk.wptr_gray", 32'(wptr_gray), 32'h200);
        rptr_gray = 10'h200;
        step(); step(); step();
        winc = 1'b1;
        step();
        chk("wrap1.wr_addr", 32'(wr_addr), 0);
        chk("wrap1.wptr_gray", 32'(wptr_gray), 0);
        chk("wrap1.full", 32'(full), 0);
        chk("wrap1.wr_level", 32'(wr_level), 1);
        step();
        chk("wrap2.wr_addr", 32'(wr_addr), 1);
        chk("wrap2.wptr_gray", 32'(wptr_gray), 1);
        chk("wrap2.full", 32'(full), 0);
        chk("wrap2.wr_level", 32'(wr_level), 2);

        // Read pointer at 812 makes the FIFO full after 300 writes.
        wrst = 1'b1; winc = 1'b0;
        step();
        wrst = 1'b0; winc = 1'b1; rptr_gray = gray(10'd812);
        for (int i = 0; i < 300; i++) step();
        chk("mid.wr_addr", 32'(wr_addr), 300);
        chk("mid.full", 32'(full), 1);
        chk("mid.wr_level", 32'(wr_level), 512);
        step();
        chk("mid.overflow", 32'(overflow), 1);
        chk("mid.wr_addr_held", 32'(wr_addr), 300);
        wrst = 1'b1;
        step();
        chk_zero("midreset");
        wrst = 1'b0; rptr_gray = '0;
        step();
        chk("post.wr_addr", 32'(wr_addr), 1);
        chk("post.wr_level", 32'(wr_level), 1);
        chk("post.overflow", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
